// File: rtl/iobus_pkg.sv
// ---------------------------------------------------------------------------
// iobus_pkg
//   Shared definitions for IOBUS responders: word offsets of the timer
//   registers (IOBUS_ADDR[4:2]), CTRL bit positions and the CTRL struct,
//   plus helpers that pack/unpack CTRL to and from a 32-bit bus word.
// ---------------------------------------------------------------------------
package iobus_pkg;

  // Word offsets within the 32-byte block (byte offset / 4)
  localparam logic [2:0] CTRL_OFS     = 3'd0;
  localparam logic [2:0] PRESCALE_OFS = 3'd1;
  localparam logic [2:0] COMPARE_OFS  = 3'd2;
  localparam logic [2:0] COUNT_OFS    = 3'd3;
  localparam logic [2:0] STATUS_OFS   = 3'd4;

  // Number of word slots decoded inside one block
  localparam int NUM_SLOTS = 8;

  // CTRL bit indices
  localparam int EN_BIT   = 0;
  localparam int AUTO_BIT = 1;
  localparam int IEN_BIT  = 2;

  // STATUS bit index
  localparam int PEND_BIT = 0;

  // CTRL register contents; packed MSB-first so en lands on bit 0
  typedef struct packed {
    logic ien;
    logic auto_reload;
    logic en;
  } ctrl_t;

  // Extract CTRL fields from a bus write word; unused bits are dropped
  function automatic ctrl_t ctrl_from_word(input logic [31:0] word);
    ctrl_t c;
    c.en          = word[EN_BIT];
    c.auto_reload = word[AUTO_BIT];
    c.ien         = word[IEN_BIT];
    return c;
  endfunction

  // Present CTRL on the read bus; undefined bits read as zero
  function automatic logic [31:0] ctrl_to_word(input ctrl_t c);
    logic [31:0] word;
    word           = '0;
    word[EN_BIT]   = c.en;
    word[AUTO_BIT] = c.auto_reload;
    word[IEN_BIT]  = c.ien;
    return word;
  endfunction

endpackage

// File: rtl/iobus_tick_gen.sv
// ---------------------------------------------------------------------------
// iobus_tick_gen
//   Prescale counter. Counts 0..period while enabled and asserts tick in the
//   cycle where the count equals period; the count then returns to 0.
//   Held at 0 while disabled, so a freshly enabled timer with period=0 ticks
//   in its very first enabled cycle.
// Ports:
//   CLK     in   system clock, rising edge
//   RST_N   in   asynchronous active-low reset
//   enable  in   counting enable (timer EN)
//   period  in   prescale value; tick every period+1 enabled cycles
//   tick    out  one-cycle pulse, combinational from flops only
// ---------------------------------------------------------------------------
module iobus_tick_gen #(
  parameter int PRESCALE_W = 16
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] period,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] pcnt_reg;
  logic [PRESCALE_W-1:0] pcnt_next;

  assign tick = enable && (pcnt_reg == period);

  always_comb begin
    pcnt_next = pcnt_reg + 1'b1;
    if (!enable || tick) begin
      pcnt_next = '0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pcnt_reg <= '0;
    end else begin
      pcnt_reg <= pcnt_next;
    end
  end

endmodule

// File: rtl/iobus_timer.sv
// ---------------------------------------------------------------------------
// iobus_timer
//   IOBUS responder with a prescaled compare-match counter and a level
//   interrupt. Registers (word offsets): CTRL, PRESCALE, COMPARE, COUNT,
//   STATUS; remaining slots of the 32-byte block read 0 and ignore writes.
// Ports:
//   CLK         in   system clock, rising edge
//   RST_N       in   asynchronous active-low reset
//   IOBUS_ADDR  in   byte address; [31:5] selects the block, [4:2] the word
//   IOBUS_OUT   in   write data from the MCU
//   IOBUS_WR    in   write strobe, one cycle per store
//   IOBUS_IN    out  registered read data (one cycle latency, 0 if unselected)
//   INT         out  interrupt request = PEND && IEN, from a flop
// ---------------------------------------------------------------------------
module iobus_timer
  import iobus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h1100_0100,
  parameter int          PRESCALE_W = 16
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] IOBUS_IN,
  output logic        INT
);

  // -------------------------------------------------------------------------
  // Address decode
  // -------------------------------------------------------------------------
  logic                 sel;
  logic [2:0]           ofs;
  logic [NUM_SLOTS-1:0] wr_slot;
  logic [1:0]           unused_byte_lane;

  assign sel              = (IOBUS_ADDR[31:5] == BASE_ADDR[31:5]);
  assign ofs              = IOBUS_ADDR[4:2];
  assign unused_byte_lane = IOBUS_ADDR[1:0];

  // One write strobe per word slot; unmapped slots simply go unused
  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_wr_slot
    assign wr_slot[gi] = IOBUS_WR && sel && (ofs == 3'(gi));
  end

  logic wr_ctrl;
  logic wr_prescale;
  logic wr_compare;
  logic wr_count;
  logic wr_status;

  assign wr_ctrl     = wr_slot[CTRL_OFS];
  assign wr_prescale = wr_slot[PRESCALE_OFS];
  assign wr_compare  = wr_slot[COMPARE_OFS];
  assign wr_count    = wr_slot[COUNT_OFS];
  assign wr_status   = wr_slot[STATUS_OFS];

  // -------------------------------------------------------------------------
  // Register state
  // -------------------------------------------------------------------------
  ctrl_t                 ctrl_reg,     ctrl_next;
  logic [PRESCALE_W-1:0] prescale_reg, prescale_next;
  logic [31:0]           compare_reg,  compare_next;
  logic [31:0]           count_reg,    count_next;
  logic                  pend_reg,     pend_next;
  logic [31:0]           rdata_reg,    rdata_next;
  logic                  int_reg,      int_next;

  // -------------------------------------------------------------------------
  // Prescaler
  // -------------------------------------------------------------------------
  logic tick;
  logic match;

  iobus_tick_gen #(
    .PRESCALE_W (PRESCALE_W)
  ) u_tick_gen (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .enable (ctrl_reg.en),
    .period (prescale_reg),
    .tick   (tick)
  );

  assign match = tick && (count_reg == compare_reg);

  // -------------------------------------------------------------------------
  // Next-state: timer events first, software writes last so that a write to
  // COUNT or CTRL wins over the same-edge timer update. PEND is the
  // exception: a match set wins over a STATUS clear.
  // -------------------------------------------------------------------------
  always_comb begin
    ctrl_next     = ctrl_reg;
    prescale_next = prescale_reg;
    compare_next  = compare_reg;
    count_next    = count_reg;
    pend_next     = pend_reg;

    if (match) begin
      if (ctrl_reg.auto_reload) begin
        count_next = '0;
      end else begin
        ctrl_next.en = 1'b0;   // one-shot: stop, COUNT holds at COMPARE
      end
    end else if (tick) begin
      count_next = count_reg + 32'd1;   // natural modulo-2^32 wrap
    end

    if (wr_status && IOBUS_OUT[PEND_BIT]) begin
      pend_next = 1'b0;
    end
    if (match) begin
      pend_next = 1'b1;
    end

    if (wr_ctrl) begin
      ctrl_next = ctrl_from_word(IOBUS_OUT);
    end
    if (wr_prescale) begin
      prescale_next = IOBUS_OUT[PRESCALE_W-1:0];
    end
    if (wr_compare) begin
      compare_next = IOBUS_OUT;
    end
    if (wr_count) begin
      count_next = IOBUS_OUT;
    end
  end

  // INT is registered from the next-state values so it tracks PEND && IEN
  // with no extra cycle and without a gate between flops and the pin.
  assign int_next = pend_next && ctrl_next.ien;

  // -------------------------------------------------------------------------
  // Read mux: samples current (pre-write) register values
  // -------------------------------------------------------------------------
  always_comb begin
    rdata_next = '0;
    if (sel) begin
      unique case (ofs)
        CTRL_OFS:     rdata_next = ctrl_to_word(ctrl_reg);
        PRESCALE_OFS: rdata_next = 32'(prescale_reg);
        COMPARE_OFS:  rdata_next = compare_reg;
        COUNT_OFS:    rdata_next = count_reg;
        STATUS_OFS:   rdata_next = {31'd0, pend_reg};
        default:      rdata_next = '0;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ctrl_reg     <= '0;
      prescale_reg <= '0;
      compare_reg  <= '0;
      count_reg    <= '0;
      pend_reg     <= 1'b0;
      rdata_reg    <= '0;
      int_reg      <= 1'b0;
    end else begin
      ctrl_reg     <= ctrl_next;
      prescale_reg <= prescale_next;
      compare_reg  <= compare_next;
      count_reg    <= count_next;
      pend_reg     <= pend_next;
      rdata_reg    <= rdata_next;
      int_reg      <= int_next;
    end
  end

  assign IOBUS_IN = rdata_reg;
  assign INT      = int_reg;

endmodule

// File: tb/tb_iobus_timer.sv
// ---------------------------------------------------------------------------
// tb_iobus_timer
//   Drives one bus transaction per cycle. Each transaction steps a
//   behavioural model of the timer and queues the expected IOBUS_IN / INT
//   seen after the sampling edge; a monitor pops and compares every cycle.
//   Directed sequences additionally check hand-derived constants.
// ---------------------------------------------------------------------------
module tb_iobus_timer;

  localparam logic [31:0] BASE    = 32'h1100_0100;
  localparam logic [26:0] BASE_HI = BASE[31:5];
  localparam logic [31:0] A_CTRL  = BASE + 32'h00;
  localparam logic [31:0] A_PRE   = BASE + 32'h04;
  localparam logic [31:0] A_CMP   = BASE + 32'h08;
  localparam logic [31:0] A_CNT   = BASE + 32'h0C;
  localparam logic [31:0] A_STAT  = BASE + 32'h10;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b1;
  logic [31:0] IOBUS_ADDR = '0;
  logic [31:0] IOBUS_OUT = '0;
  logic        IOBUS_WR = 1'b0;
  logic [31:0] IOBUS_IN;
  logic        INT;

  always #5 CLK = ~CLK;

  iobus_timer #(
    .BASE_ADDR  (BASE),
    .PRESCALE_W (16)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .IOBUS_ADDR (IOBUS_ADDR),
    .IOBUS_OUT  (IOBUS_OUT),
    .IOBUS_WR   (IOBUS_WR),
    .IOBUS_IN   (IOBUS_IN),
    .INT        (INT)
  );

  typedef struct {
    logic [31:0] rd;
    logic        irq;
    string       tag;
  } exp_t;

  exp_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Behavioural model state
  logic        m_en, m_auto, m_ien, m_pend;
  logic [15:0] m_pre, m_pcnt;
  logic [31:0] m_cmp, m_cnt;

  function automatic void model_reset();
    m_en = 0; m_auto = 0; m_ien = 0; m_pend = 0;
    m_pre = 0; m_pcnt = 0; m_cmp = 0; m_cnt = 0;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (a[31:5] != BASE_HI) return 32'd0;
    case (a[4:2])
      3'd0: return {29'd0, m_ien, m_auto, m_en};
      3'd1: return {16'd0, m_pre};
      3'd2: return m_cmp;
      3'd3: return m_cnt;
      3'd4: return {31'd0, m_pend};
      default: return 32'd0;
    endcase
  endfunction

  // One bus cycle: drive inputs, advance the model by one clock, queue result
  task automatic cyc(input logic [31:0] a, input logic [31:0] d, input logic w, input string tag);
    exp_t        e;
    logic        hit, tick, matched;
    logic [2:0]  o;
    @(negedge CLK);
    IOBUS_ADDR = a;
    IOBUS_OUT  = d;
    IOBUS_WR   = w;
    hit  = (a[31:5] == BASE_HI);
    o    = a[4:2];
    e.rd = m_read(a);
    tick    = m_en && (m_pcnt == m_pre);
    matched = tick && (m_cnt == m_cmp);
    if (w && hit && o == 3'd4 && d[0]) m_pend = 1'b0;
    if (matched) begin
      m_pend = 1'b1;
      if (m_auto) m_cnt = 32'd0;
      else        m_en  = 1'b0;
    end else if (tick) begin
      m_cnt = m_cnt + 32'd1;
    end
    m_pcnt = (tick || !m_en) ? 16'd0 : m_pcnt + 16'd1;
    // one-shot stop is evaluated before EN changes the prescaler above;
    // the prescaler uses the EN value that was current during the cycle
    if (matched && !m_auto) m_pcnt = 16'd0;
    if (w && hit) begin
      case (o)
        3'd0: begin m_en = d[0]; m_auto = d[1]; m_ien = d[2]; end
        3'd1: m_pre = d[15:0];
        3'd2: m_cmp = d;
        3'd3: m_cnt = d;
        default: ;
      endcase
    end
    e.irq = m_pend && m_ien;
    e.tag = tag;
    sb_q.push_back(e);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cyc(a, d, 1'b1, "write");
  endtask

  // Read and also compare against a hand-derived constant after the edge
  task automatic rd_expect(input logic [31:0] a, input logic [31:0] exp_rd,
                           input logic exp_irq, input string tag);
    cyc(a, 32'd0, 1'b0, tag);
    @(posedge CLK);
    #2;
    vectors++;
    if (IOBUS_IN !== exp_rd || INT !== exp_irq) begin
      miscompares++;
      $display("FAIL %s: got rd=%08h int=%b, want rd=%08h int=%b",
               tag, IOBUS_IN, INT, exp_rd, exp_irq);
    end
  endtask

  task automatic check_now(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %08h, want %08h", tag, got, want);
    end
  endtask

  // Asynchronous reset in the middle of a cycle
  task automatic do_reset();
    @(posedge CLK);
    #3;
    IOBUS_WR = 1'b0;
    RST_N    = 1'b0;
    #1;
    check_now("reset_int", {31'd0, INT}, 32'd0);
    check_now("reset_iobus_in", IOBUS_IN, 32'd0);
    model_reset();
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  // Monitor: one expected entry per sampling edge
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        vectors++;
        if (IOBUS_IN !== e.rd || INT !== e.irq) begin
          miscompares++;
          $display("FAIL sb_%s: got rd=%08h int=%b, want rd=%08h int=%b",
                   e.tag, IOBUS_IN, INT, e.rd, e.irq);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a, d;
    int          o;

    model_reset();
    #1 RST_N = 1'b0;
    #1;
    check_now("por_int", {31'd0, INT}, 32'd0);
    check_now("por_iobus_in", IOBUS_IN, 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;

    // Reset state of every register
    for (int i = 0; i < 5; i++) rd_expect(BASE + 32'(4 * i), 32'd0, 1'b0, "reset_state");

    // Auto-reload match: E0 = CTRL write
    wr(A_PRE, 0); wr(A_CMP, 3); wr(A_CNT, 0);
    wr(A_CTRL, 32'h7);
    rd_expect(A_CNT, 0, 0, "auto_e1");
    rd_expect(A_CNT, 1, 0, "auto_e2");
    rd_expect(A_CNT, 2, 0, "auto_e3");
    rd_expect(A_CNT, 3, 1, "auto_e4_match");
    rd_expect(A_CNT, 0, 1, "auto_e5");
    rd_expect(A_CNT, 1, 1, "auto_e6");
    rd_expect(A_CNT, 2, 1, "auto_e7");
    rd_expect(A_CNT, 3, 1, "auto_e8_match");
    rd_expect(A_CNT, 0, 1, "auto_e9");

    // Clear/set collision and IEN masking
    wr(A_CTRL, 0); wr(A_STAT, 1); wr(A_CNT, 0);
    wr(A_CTRL, 32'h7);
    rd_expect(A_CNT, 0, 0, "coll_e1");
    rd_expect(A_CNT, 1, 0, "coll_e2");
    rd_expect(A_CNT, 2, 0, "coll_e3");
    wr(A_STAT, 1);                          // E4: match on the same edge
    rd_expect(A_STAT, 1, 1, "coll_pend_kept");
    wr(A_STAT, 1);                          // E6: no match, clears
    rd_expect(A_STAT, 0, 0, "coll_pend_cleared");
    wr(A_CTRL, 32'h3);                      // E8: match, IEN dropped
    rd_expect(A_STAT, 1, 0, "ien_mask");
    rd_expect(A_CTRL, 3, 0, "ien_ctrl");

    // One-shot
    wr(A_CTRL, 0); wr(A_STAT, 1); wr(A_CNT, 0); wr(A_CMP, 2);
    wr(A_CTRL, 32'h5);
    rd_expect(A_CNT, 0, 0, "one_e1");
    rd_expect(A_CNT, 1, 0, "one_e2");
    rd_expect(A_CNT, 2, 1, "one_e3_match");
    rd_expect(A_CTRL, 4, 1, "one_ctrl");
    rd_expect(A_CNT, 2, 1, "one_hold");
    rd_expect(A_CNT, 2, 1, "one_hold2");
    rd_expect(A_STAT, 1, 1, "one_pend");

    // Prescale: tick every 5 cycles
    wr(A_CTRL, 0); wr(A_STAT, 1); wr(A_PRE, 4); wr(A_CMP, 32'hFFFF_FFFF); wr(A_CNT, 0);
    wr(A_CTRL, 32'h1);
    for (int k = 1; k <= 15; k++) rd_expect(A_CNT, 32'((k - 1) / 5), 0, "prescale");

    // Wrap without PEND
    wr(A_CTRL, 0); wr(A_PRE, 0); wr(A_CMP, 16); wr(A_CNT, 32'hFFFF_FFFE);
    wr(A_CTRL, 32'h1);
    rd_expect(A_CNT, 32'hFFFF_FFFE, 0, "wrap_e1");
    rd_expect(A_CNT, 32'hFFFF_FFFF, 0, "wrap_e2");
    rd_expect(A_CNT, 32'h0, 0, "wrap_e3");
    rd_expect(A_STAT, 0, 0, "wrap_no_pend");

    // Bus decode
    wr(A_CTRL, 0); wr(A_CMP, 32'hDEAD_BEEF);
    rd_expect(A_CMP, 32'hDEAD_BEEF, 0, "dec_compare");
    rd_expect(A_CMP + 32'd3, 32'hDEAD_BEEF, 0, "dec_byte_lane");
    wr(BASE + 32'h18, 32'h1234_5677);
    wr(BASE + 32'h20, 32'hFFFF_FFFF);
    wr(A_CTRL, 32'hFFFF_FFF8);
    rd_expect(BASE + 32'h18, 0, 0, "dec_unmapped");
    rd_expect(BASE + 32'h20, 0, 0, "dec_foreign");
    rd_expect(A_CTRL, 0, 0, "dec_ctrl_untouched");
    rd_expect(A_CMP, 32'hDEAD_BEEF, 0, "dec_compare_untouched");

    // Randomized traffic checked only through the model
    for (int n = 0; n < 600; n++) begin
      o = $urandom_range(0, 7);
      a = BASE + 32'(4 * o) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) a = a ^ (32'd1 << (5 + $urandom_range(0, 26)));
      case (o)
        1: d = 32'($urandom_range(0, 3));
        2: d = 32'($urandom_range(0, 12));
        3: d = 32'($urandom_range(0, 12));
        default: d = $urandom;
      endcase
      cyc(a, d, ($urandom_range(0, 2) == 0), "random");
    end

    // Reset mid-count
    wr(A_CTRL, 0); wr(A_PRE, 0); wr(A_CMP, 100); wr(A_CNT, 0);
    wr(A_CTRL, 32'h7);
    for (int k = 0; k < 40; k++) cyc(A_CNT, 0, 1'b0, "pre_reset");
    do_reset();
    for (int i = 0; i < 5; i++) rd_expect(BASE + 32'(4 * i), 32'd0, 1'b0, "post_reset");

    @(posedge CLK);
    #3;
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL sb_drain: got %0d pending, want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
